// File: rtl/rx_path_if.sv
// Receive-side link bundle: serial line and parity format in, word and status strobes out.
interface rx_path_if #(
    parameter int unsigned WIDTH_SIZE = 8
);
    logic                  Rx;
    logic                  PF;
    logic [WIDTH_SIZE-1:0] data_out;
    logic                  valid_out;
    logic                  parity_err;
    logic                  frame_err;
    logic                  busy;

    // Line driver / consumer side
    modport master (
        output Rx,
        output PF,
        input  data_out,
        input  valid_out,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    // Receiver side
    modport slave (
        input  Rx,
        input  PF,
        output data_out,
        output valid_out,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/rx_path.sv
// One-bit-per-clock serial receiver: start detect, LSB-first deserialise, even parity
// (single or per-8-bit-group), stop check, word plus one-cycle strobes.
module rx_path #(
    parameter int unsigned WIDTH_SIZE = 8
) (
    input  logic      clk,
    input  logic      reset,
    rx_path_if.slave  io_bus
);
    localparam int unsigned     IdxW    = $clog2(WIDTH_SIZE + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH_SIZE - 1);
    localparam logic [IdxW-1:0] NumBits = IdxW'(WIDTH_SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e                r_state, w_state_nxt;
    logic                  r_pf, w_pf_nxt;
    logic [IdxW-1:0]       r_idx, w_idx_nxt;
    logic [3:0]            r_grp, w_grp_nxt;
    logic                  r_acc, w_acc_nxt;
    logic                  r_err, w_err_nxt;
    logic [WIDTH_SIZE-1:0] r_shadow, w_shadow_nxt;
    logic [WIDTH_SIZE-1:0] r_data, w_data_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_perr, w_perr_nxt;
    logic                  r_ferr, w_ferr_nxt;

    // State and datapath registers; reset discards any partial frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_pf     <= 1'b0;
            r_idx    <= '0;
            r_grp    <= '0;
            r_acc    <= 1'b0;
            r_err    <= 1'b0;
            r_shadow <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pf     <= w_pf_nxt;
            r_idx    <= w_idx_nxt;
            r_grp    <= w_grp_nxt;
            r_acc    <= w_acc_nxt;
            r_err    <= w_err_nxt;
            r_shadow <= w_shadow_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_perr   <= w_perr_nxt;
            r_ferr   <= w_ferr_nxt;
        end
    end

    // Next-state and datapath update; strobes default low so they last one cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_pf_nxt     = r_pf;
        w_idx_nxt    = r_idx;
        w_grp_nxt    = r_grp;
        w_acc_nxt    = r_acc;
        w_err_nxt    = r_err;
        w_shadow_nxt = r_shadow;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;
        w_perr_nxt   = 1'b0;
        w_ferr_nxt   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (!io_bus.Rx) begin
                    w_pf_nxt    = io_bus.PF;
                    w_idx_nxt   = '0;
                    w_grp_nxt   = '0;
                    w_acc_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = StData;
                end
            end
            StData: begin
                for (int i = 0; i < int'(WIDTH_SIZE); i++) begin
                    if (r_idx == IdxW'(i)) begin
                        w_shadow_nxt[i] = io_bus.Rx;
                    end
                end
                w_acc_nxt = r_acc ^ io_bus.Rx;
                w_idx_nxt = r_idx + 1'b1;
                w_grp_nxt = r_grp + 1'b1;
                // A full group and the last bit coinciding yields a single parity bit
                if ((r_pf && (r_grp == 4'd7)) || (r_idx == LastIdx)) begin
                    w_state_nxt = StParity;
                end
            end
            StParity: begin
                if (io_bus.Rx != r_acc) begin
                    w_err_nxt = 1'b1;
                end
                if (r_idx < NumBits) begin
                    w_acc_nxt   = 1'b0;
                    w_grp_nxt   = '0;
                    w_state_nxt = StData;
                end else begin
                    w_state_nxt = StStop;
                end
            end
            StStop: begin
                if (io_bus.Rx) begin
                    w_data_nxt  = r_shadow;
                    w_valid_nxt = 1'b1;
                    w_perr_nxt  = r_err;
                    w_state_nxt = StIdle;
                end else begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = StBreak;
                end
            end
            StBreak: begin
                if (io_bus.Rx) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign io_bus.data_out   = r_data;
    assign io_bus.valid_out  = r_valid;
    assign io_bus.parity_err = r_perr;
    assign io_bus.frame_err  = r_ferr;
    assign io_bus.busy       = (r_state == StData) || (r_state == StParity) ||
                               (r_state == StStop);
endmodule
